// File: rtl/sevenseg_mux.sv
// Two-digit multiplexed seven-segment driver: DEAD1 -> DIGIT1 -> DEAD2 -> DIGIT2, all outputs registered.
// Outputs change on the edge entering a state; free-running, no backpressure; digit values latched on entry.
module sevenseg_mux #(
   parameter int REFRESH_CYCLES = 24000,
   parameter int DEAD_CYCLES    = 240
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] s1,
   input  logic [3:0] s2,
   output logic [6:0] seg,
   output logic       an1,
   output logic       an2,
   output logic       frame
);

   localparam int MAXC = (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] REF_LAST  = CW'(REFRESH_CYCLES - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {DEAD1, DIGIT1, DEAD2, DIGIT2} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [3:0]    d1, d2, d1_nxt, d2_nxt;
   logic [6:0]    seg_nxt;
   logic          an1_nxt, an2_nxt, frame_nxt;
   logic          last;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] c;
      case (v)
         4'h0:    c = 7'b1000000;
         4'h1:    c = 7'b1111001;
         4'h2:    c = 7'b0100100;
         4'h3:    c = 7'b0110000;
         4'h4:    c = 7'b0011001;
         4'h5:    c = 7'b0010010;
         4'h6:    c = 7'b0000010;
         4'h7:    c = 7'b1111000;
         4'h8:    c = 7'b0000000;
         4'h9:    c = 7'b0010000;
         4'hA:    c = 7'b0001000;
         4'hB:    c = 7'b0000011;
         4'hC:    c = 7'b1000110;
         4'hD:    c = 7'b0100001;
         4'hE:    c = 7'b0000110;
         default: c = 7'b0001110;
      endcase
      return c;
   endfunction

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      d1_nxt    = d1;
      d2_nxt    = d2;
      last      = 1'b0;
      seg_nxt   = 7'b1111111;
      an1_nxt   = 1'b1;
      an2_nxt   = 1'b1;
      frame_nxt = 1'b0;

      case (state)
         DIGIT1, DIGIT2: last = (cnt == REF_LAST);
         default:        last = (cnt == DEAD_LAST);
      endcase

      if (last) begin
         cnt_nxt = '0;
         case (state)
            DEAD1: begin
               state_nxt = DIGIT1;
               d1_nxt    = s1;
            end
            DIGIT1: state_nxt = DEAD2;
            DEAD2: begin
               state_nxt = DIGIT2;
               d2_nxt    = s2;
            end
            default: state_nxt = DEAD1;
         endcase
      end

      // Outputs are computed from the upcoming state so the registers line up with it.
      case (state_nxt)
         DIGIT1: begin
            an1_nxt = 1'b0;
            seg_nxt = decode(d1_nxt);
         end
         DIGIT2: begin
            an2_nxt   = 1'b0;
            seg_nxt   = decode(d2_nxt);
            frame_nxt = (cnt_nxt == REF_LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= DEAD1;
         cnt   <= '0;
         d1    <= 4'h0;
         d2    <= 4'h0;
         seg   <= 7'b1111111;
         an1   <= 1'b1;
         an2   <= 1'b1;
         frame <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         d1    <= d1_nxt;
         d2    <= d2_nxt;
         seg   <= seg_nxt;
         an1   <= an1_nxt;
         an2   <= an2_nxt;
         frame <= frame_nxt;
      end
   end

endmodule

// File: tb/tb_sevenseg_mux.sv
// Directed bench for sevenseg_mux with REFRESH_CYCLES=8, DEAD_CYCLES=2 (frame = 20 cycles).
module tb_sevenseg_mux;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] s1 = 4'h0;
   logic [3:0] s2 = 4'h0;
   logic [6:0] seg;
   logic       an1, an2, frame;

   int n_checks = 0;
   int n_fail   = 0;
   logic [6:0] code [16];

   always #5 clk = ~clk;

   sevenseg_mux #(.REFRESH_CYCLES(8), .DEAD_CYCLES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .s1    (s1),
      .s2    (s2),
      .seg   (seg),
      .an1   (an1),
      .an2   (an2),
      .frame (frame)
   );

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   // Leaves the caller at the sample point of the first DIGIT1 cycle.
   task automatic sync_digit1(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (an1 === 1'b0) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL %s: an1 never went low within 60 cycles (an1=%b)", tag, an1);
      end
   endtask

   task automatic test_reset();
      s1 = 4'h5;
      s2 = 4'h0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if ({an1, an2, seg, frame} !== {2'b11, 7'b1111111, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_async: an1=%b an2=%b seg=%b frame=%b, want 1 1 1111111 0", an1, an2, seg, frame);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({an1, an2, seg, frame} !== {2'b11, 7'b1111111, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold%0d: an1=%b an2=%b seg=%b frame=%b, want 1 1 1111111 0", i, an1, an2, seg, frame);
         end
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({an1, an2, seg} !== {2'b11, 7'b1111111}) begin
         n_fail++;
         $display("FAIL release_c0: an1=%b an2=%b seg=%b, want 1 1 1111111", an1, an2, seg);
      end
      @(negedge clk);
      n_checks++;
      if ({an1, an2, seg} !== {2'b11, 7'b1111111}) begin
         n_fail++;
         $display("FAIL release_c1: an1=%b an2=%b seg=%b, want 1 1 1111111", an1, an2, seg);
      end
      @(negedge clk);
      n_checks++;
      if ({an1, an2, seg} !== {2'b01, 7'b0010010}) begin
         n_fail++;
         $display("FAIL first_digit1: an1=%b an2=%b seg=%b, want 0 1 0010010", an1, an2, seg);
      end
   endtask

   task automatic test_decode();
      s1 = 4'h0;
      s2 = 4'h0;
      apply_reset();
      sync_digit1("decode_sync");
      for (int i = 0; i < 256; i++) begin
         logic [7:0] cur;
         logic [7:0] nx;
         cur = 8'(i);
         nx  = 8'(i + 1);
         n_checks++;
         if (an1 !== 1'b0 || seg !== code[cur[7:4]]) begin
            n_fail++;
            $display("FAIL decode_s1 %h: an1=%b seg=%b, want 0 %b", cur[7:4], an1, seg, code[cur[7:4]]);
         end
         repeat (10) @(negedge clk);
         n_checks++;
         if (an2 !== 1'b0 || seg !== code[cur[3:0]]) begin
            n_fail++;
            $display("FAIL decode_s2 %h: an2=%b seg=%b, want 0 %b", cur[3:0], an2, seg, code[cur[3:0]]);
         end
         s1 = nx[7:4];
         s2 = nx[3:0];
         repeat (10) @(negedge clk);
      end
   endtask

   task automatic test_latch();
      s1 = 4'h3;
      apply_reset();
      sync_digit1("latch_sync");
      for (int t = 0; t < 8; t++) begin
         if (t == 3) s1 = 4'h8;
         n_checks++;
         if (an1 !== 1'b0 || seg !== 7'b0110000) begin
            n_fail++;
            $display("FAIL latch_hold t=%0d: an1=%b seg=%b, want 0 0110000", t, an1, seg);
         end
         @(negedge clk);
      end
      repeat (12) @(negedge clk);
      n_checks++;
      if (an1 !== 1'b0 || seg !== 7'b0000000) begin
         n_fail++;
         $display("FAIL latch_next: an1=%b seg=%b, want 0 0000000", an1, seg);
      end
   endtask

   task automatic test_timing();
      int run1 = 0, run2 = 0, gap = 0, since = 0;
      int nframes = 0, nwin1 = 0, nwin2 = 0, nboth = 0;
      bit seen_low = 1'b0;
      s1 = 4'h1;
      s2 = 4'h7;
      apply_reset();
      sync_digit1("timing_sync");
      for (int t = 0; t < 102; t++) begin
         if (an1 === 1'b0 && an2 === 1'b0) nboth++;
         if (an1 === 1'b0) run1++;
         else if (run1 > 0) begin
            n_checks++;
            if (run1 != 8) begin
               n_fail++;
               $display("FAIL an1_window t=%0d: %0d cycles, want 8", t, run1);
            end
            nwin1++;
            run1 = 0;
         end
         if (an2 === 1'b0) run2++;
         else if (run2 > 0) begin
            n_checks++;
            if (run2 != 8) begin
               n_fail++;
               $display("FAIL an2_window t=%0d: %0d cycles, want 8", t, run2);
            end
            nwin2++;
            run2 = 0;
         end
         if (an1 === 1'b1 && an2 === 1'b1) gap++;
         else begin
            if (gap > 0 && seen_low) begin
               n_checks++;
               if (gap != 2) begin
                  n_fail++;
                  $display("FAIL dark_gap t=%0d: %0d cycles, want 2", t, gap);
               end
            end
            gap = 0;
            seen_low = 1'b1;
         end
         if (frame === 1'b1) begin
            n_checks++;
            if (an2 !== 1'b0 || (nframes > 0 && since != 20)) begin
               n_fail++;
               $display("FAIL frame_pulse t=%0d: spacing=%0d an2=%b, want 20 and an2=0", t, since, an2);
            end
            nframes++;
            since = 0;
         end
         since++;
         @(negedge clk);
      end
      n_checks++;
      if (nboth != 0 || nframes != 5 || nwin1 != 5 || nwin2 != 5) begin
         n_fail++;
         $display("FAIL timing_totals: both_low=%0d frames=%0d win1=%0d win2=%0d, want 0 5 5 5",
                  nboth, nframes, nwin1, nwin2);
      end
   endtask

   task automatic test_midreset();
      int nfr = 0;
      s1 = 4'h2;
      s2 = 4'hE;
      apply_reset();
      sync_digit1("midreset_sync");
      repeat (14) @(negedge clk);
      n_checks++;
      if (an2 !== 1'b0 || seg !== 7'b0000110) begin
         n_fail++;
         $display("FAIL midreset_pre: an2=%b seg=%b, want 0 0000110", an2, seg);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({an1, an2, seg} !== {2'b11, 7'b1111111}) begin
         n_fail++;
         $display("FAIL midreset_async: an1=%b an2=%b seg=%b, want 1 1 1111111", an1, an2, seg);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (frame !== 1'b0) nfr++;
      end
      reset = 1'b1;
      #1;
      if (frame !== 1'b0) nfr++;
      n_checks++;
      if ({an1, an2, seg} !== {2'b11, 7'b1111111}) begin
         n_fail++;
         $display("FAIL midreset_dead1a: an1=%b an2=%b seg=%b, want 1 1 1111111", an1, an2, seg);
      end
      @(negedge clk);
      if (frame !== 1'b0) nfr++;
      n_checks++;
      if ({an1, an2, seg} !== {2'b11, 7'b1111111}) begin
         n_fail++;
         $display("FAIL midreset_dead1b: an1=%b an2=%b seg=%b, want 1 1 1111111", an1, an2, seg);
      end
      @(negedge clk);
      if (frame !== 1'b0) nfr++;
      n_checks++;
      if ({an1, an2, seg} !== {2'b01, 7'b0100100}) begin
         n_fail++;
         $display("FAIL midreset_digit1: an1=%b an2=%b seg=%b, want 0 1 0100100", an1, an2, seg);
      end
      n_checks++;
      if (nfr != 0) begin
         n_fail++;
         $display("FAIL midreset_frame: %0d frame cycles seen, want 0", nfr);
      end
   endtask

   initial begin
      code[0]  = 7'b1000000; code[1]  = 7'b1111001; code[2]  = 7'b0100100; code[3]  = 7'b0110000;
      code[4]  = 7'b0011001; code[5]  = 7'b0010010; code[6]  = 7'b0000010; code[7]  = 7'b1111000;
      code[8]  = 7'b0000000; code[9]  = 7'b0010000; code[10] = 7'b0001000; code[11] = 7'b0000011;
      code[12] = 7'b1000110; code[13] = 7'b0100001; code[14] = 7'b0000110; code[15] = 7'b0001110;
      test_reset();
      test_decode();
      test_latch();
      test_timing();
      test_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded 1000000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
